// File: rtl/blowfish128_ffunc.sv
// blowfish128_ffunc: responder for the Blowfish-128 F-function handshake.
// Computes Y = {F(X[63:32]), F(X[31:0])} with F(h) = ((S0[a]+S1[b])^S2[c])+S3[d]
// using S-box lookups over several cycles, then pulses ffunc_ready for one cycle.
// Owns the four 256x32 S-boxes (one flat 1024-word array, index {sel, addr}).
// Build option: BLOWFISH128_FFUNC_PARALLEL_EN processes both halves at once
// (4 lookup cycles, two read ports); otherwise 8 sequential lookup cycles.
//
// state    | meaning
// IDLE     | waiting for ffunc_enable
// LOOKUP   | one S-box step per cycle, idx counts steps
// DONE     | ffunc_ready high for this single cycle
// WAIT_LOW | result delivered, waiting for enable to drop
module blowfish128_ffunc #(
  parameter string SBOX_INIT = ""
) (
  input  logic        Clk,
  input  logic        RstN,
  input  logic        ffunc_enable,
  input  logic [63:0] X,
  output logic [63:0] Y,
  output logic        ffunc_ready,
  input  logic        sbox_we,
  input  logic [1:0]  sbox_sel,
  input  logic [7:0]  sbox_addr,
  input  logic [31:0] sbox_wdata,
  output logic        busy
);

`ifdef BLOWFISH128_FFUNC_PARALLEL_EN
  localparam int IDX_W = 2;
`else
  localparam int IDX_W = 3;
`endif
  localparam logic [IDX_W-1:0] IDX_LAST = '1;

  typedef enum logic [1:0] {IDLE, LOOKUP, DONE, WAIT_LOW} state_t;

  state_t           state, state_nx;
  logic [31:0]      sbox [0:1023];
  logic [63:0]      xr;
  logic [IDX_W-1:0] idx;
  logic [1:0]       step;
  logic             last_step;

  // Byte of a half-word consumed by a given step (step 0 takes the top byte).
  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] s);
    case (s)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  // Accumulator update for one step; step 3 yields the finished F value.
  function automatic logic [31:0] mix(input logic [31:0] acc_v, input logic [31:0] rd_v,
                                      input logic [1:0] s);
    case (s)
      2'd0:    return rd_v;
      2'd2:    return acc_v ^ rd_v;
      default: return acc_v + rd_v;
    endcase
  endfunction

  assign step      = idx[1:0];
  assign busy      = (state != IDLE);
  assign last_step = (state == LOOKUP) && ffunc_enable && (idx == IDX_LAST);

  // S-box write port; reads in the same cycle see the pre-write value.
  always_ff @(posedge Clk) begin
    if (sbox_we) sbox[{sbox_sel, sbox_addr}] <= sbox_wdata;
  end

  // State register.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; dropping enable mid-lookup abandons the request.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     if (ffunc_enable) state_nx = LOOKUP;
      LOOKUP:   if (!ffunc_enable)   state_nx = IDLE;
                else if (last_step)  state_nx = DONE;
      DONE:     state_nx = WAIT_LOW;
      WAIT_LOW: if (!ffunc_enable) state_nx = IDLE;
      default:  state_nx = IDLE;
    endcase
  end

`ifdef BLOWFISH128_FFUNC_PARALLEL_EN
  logic [31:0] acc_h, acc_l, rd_h, rd_l;

  assign rd_h = sbox[{step, pick_byte(xr[63:32], step)}];
  assign rd_l = sbox[{step, pick_byte(xr[31:0], step)}];

  // Datapath: both halves advance together, Y updates only on the last step.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      xr <= '0; idx <= '0; acc_h <= '0; acc_l <= '0; Y <= '0; ffunc_ready <= 1'b0;
    end else begin
      ffunc_ready <= last_step;
      if (state == IDLE && ffunc_enable) begin
        xr  <= X;
        idx <= '0;
      end else if (state == LOOKUP && ffunc_enable) begin
        idx <= idx + IDX_W'(1);
        if (step != 2'd3) begin
          acc_h <= mix(acc_h, rd_h, step);
          acc_l <= mix(acc_l, rd_l, step);
        end else begin
          Y <= {mix(acc_h, rd_h, step), mix(acc_l, rd_l, step)};
        end
      end
    end
  end
`else
  logic [31:0] half_w, rd, acc, yh, mixed;

  assign half_w = idx[2] ? xr[31:0] : xr[63:32];
  assign rd     = sbox[{step, pick_byte(half_w, step)}];
  assign mixed  = mix(acc, rd, step);

  // Datapath: high half parks in yh so Y changes only on the final step.
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      xr <= '0; idx <= '0; acc <= '0; yh <= '0; Y <= '0; ffunc_ready <= 1'b0;
    end else begin
      ffunc_ready <= last_step;
      if (state == IDLE && ffunc_enable) begin
        xr  <= X;
        idx <= '0;
      end else if (state == LOOKUP && ffunc_enable) begin
        idx <= idx + IDX_W'(1);
        if (step != 2'd3) acc <= mixed;
        else if (!idx[2]) yh  <= mixed;
        else              Y   <= {yh, mixed};
      end
    end
  end
`endif

endmodule

// File: tb/tb_blowfish128_ffunc.sv
// tb_blowfish128_ffunc: randomized bench with an array-based F-function model.
module tb_blowfish128_ffunc;
`ifdef BLOWFISH128_FFUNC_PARALLEL_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 8;
`endif

  logic        Clk = 1'b0;
  logic        RstN = 1'b0;
  logic        ffunc_enable = 1'b0;
  logic [63:0] X = '0;
  logic [63:0] Y;
  logic        ffunc_ready;
  logic        sbox_we = 1'b0;
  logic [1:0]  sbox_sel = '0;
  logic [7:0]  sbox_addr = '0;
  logic [31:0] sbox_wdata = '0;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_s [4][256];

  always #5 Clk = ~Clk;

  blowfish128_ffunc dut (
    .Clk(Clk), .RstN(RstN), .ffunc_enable(ffunc_enable), .X(X), .Y(Y),
    .ffunc_ready(ffunc_ready), .sbox_we(sbox_we), .sbox_sel(sbox_sel),
    .sbox_addr(sbox_addr), .sbox_wdata(sbox_wdata), .busy(busy)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] f_ref(input logic [31:0] h);
    return ((ref_s[0][h[31:24]] + ref_s[1][h[23:16]]) ^ ref_s[2][h[15:8]]) + ref_s[3][h[7:0]];
  endfunction

  function automatic logic [63:0] y_ref(input logic [63:0] x);
    return {f_ref(x[63:32]), f_ref(x[31:0])};
  endfunction

  // kind 0: S_k[i] = i << 8k; kind 1: wrap pattern; otherwise random
  task automatic load_sboxes(input int kind);
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 256; i++) begin
        logic [31:0] d;
        case (kind)
          0:       d = 32'(i) << (8 * s);
          1:       d = (s == 0) ? 32'hFFFF_FFFF : (s == 1) ? 32'd1 : 32'd0;
          default: d = $urandom;
        endcase
        @(negedge Clk);
        sbox_we = 1'b1; sbox_sel = 2'(s); sbox_addr = 8'(i); sbox_wdata = d;
        ref_s[s][i] = d;
      end
    end
    @(negedge Clk);
    sbox_we = 1'b0;
  endtask

  // Full request: waits for ready, holds enable `hold` cycles past the pulse,
  // then drops it and expects the block back in IDLE one cycle later.
  task automatic do_req(input logic [63:0] x, input int hold, input bit coll,
                        output logic [63:0] y_got);
    int  lat;
    int  extra;
    bit  found;
    lat = 0; extra = 0; found = 1'b0; y_got = 'x;
    @(negedge Clk);
    ffunc_enable = 1'b1; X = x;
    for (int c = 1; c <= 40 && !found; c++) begin
      @(negedge Clk);
      if (coll && c == 1) begin
        sbox_we = 1'b1; sbox_sel = 2'd0; sbox_addr = 8'd1; sbox_wdata = 32'h10;
      end else if (coll && c == 2) begin
        sbox_we = 1'b0; ref_s[0][1] = 32'h10;
      end
      if (ffunc_ready) begin
        found = 1'b1; lat = c - 1; y_got = Y;
      end
    end
    check_val("ready_seen", 64'(found), 64'd1);
    check_val("latency", 64'(lat), 64'(LAT));
    for (int h = 0; h < hold; h++) begin
      @(negedge Clk);
      if (ffunc_ready) extra++;
    end
    check_val("single_pulse", 64'(extra), 64'd0);
    check_val("busy_wait_low", 64'(busy), 64'd1);
    ffunc_enable = 1'b0;
    @(negedge Clk);
    check_val("busy_back_idle", 64'(busy), 64'd0);
  endtask

  // Request dropped when the step-3 edge samples enable.
  task automatic do_abort(input logic [63:0] x);
    logic [63:0] y_before;
    int pulses;
    y_before = Y; pulses = 0;
    @(negedge Clk);
    ffunc_enable = 1'b1; X = x;
    repeat (4) begin
      @(negedge Clk);
      if (ffunc_ready) pulses++;
    end
    ffunc_enable = 1'b0;
    @(negedge Clk);
    check_val("abort_idle", 64'(busy), 64'd0);
    repeat (LAT + 3) begin
      @(negedge Clk);
      if (ffunc_ready) pulses++;
    end
    check_val("abort_no_ready", 64'(pulses), 64'd0);
    check_val("abort_y_hold", Y, y_before);
  endtask

  initial begin
    logic [63:0] y;
    logic [63:0] x;
    int pulses;

    repeat (3) @(negedge Clk);
    check_val("rst_y", Y, 64'd0);
    check_val("rst_ready", 64'(ffunc_ready), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);
    RstN = 1'b1;

    // Basic lookup plus the held-enable handshake.
    load_sboxes(0);
    do_req(64'h01020304_A0B0C0D0, 6, 1'b0, y);
    check_val("basic_y", y, 64'h04030201_D0C0B0A0);
    do_req(64'h0, 1, 1'b0, y);
    check_val("handshake_y0", y, 64'h0);

    // Abort after a known result.
    do_req(64'h01020304_A0B0C0D0, 1, 1'b0, y);
    do_abort(64'h05060708_090A0B0C);

    // Write collision: first read of S0[1] sees the old value.
    do_req(64'h01020304_01020304, 1, 1'b1, y);
    check_val("coll_old_hi", {32'd0, y[63:32]}, {32'd0, 32'h04030201});
    do_req(64'h01020304_01020304, 1, 1'b0, y);
    check_val("coll_new", y, 64'h04030210_04030210);

    // Mod-2^32 wrap.
    load_sboxes(1);
    x = {$urandom, $urandom};
    do_req(x, 2, 1'b0, y);
    check_val("wrap_y", y, 64'h0);

    // Random contents and operands against the model.
    load_sboxes(2);
    for (int n = 0; n < 20; n++) begin
      x = {$urandom, $urandom};
      do_req(x, int'($urandom_range(1, 4)), 1'b0, y);
      check_val("rand_y", y, y_ref(x));
      if (n % 7 == 3) do_abort({$urandom, $urandom});
    end

    // Reset mid-LOOKUP: everything clears, no pulse, S-boxes survive.
    @(negedge Clk);
    ffunc_enable = 1'b1; X = {$urandom, $urandom};
    repeat (3) @(negedge Clk);
    RstN = 1'b0;
    #1;
    check_val("midrst_y", Y, 64'd0);
    check_val("midrst_ready", 64'(ffunc_ready), 64'd0);
    check_val("midrst_busy", 64'(busy), 64'd0);
    @(negedge Clk);
    ffunc_enable = 1'b0;
    RstN = 1'b1;
    pulses = 0;
    repeat (LAT + 4) begin
      @(negedge Clk);
      if (ffunc_ready) pulses++;
    end
    check_val("midrst_no_ready", 64'(pulses), 64'd0);
    x = {$urandom, $urandom};
    do_req(x, 1, 1'b0, y);
    check_val("sbox_kept", y, y_ref(x));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
